dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
Shares the single-port data memory between two requesters: port 0 is the CPU control unit's D_rd/D_wr path, and port 1 is a host/debug loader. It serialises accesses with a req/gnt handshake and round-robin (or fixed) arbitration. It registers the memory command and returns read data with a valid strobe after the memory's read latency. It sits between the control unit / loader and the data memory.

Parameters:
ADDR_W, 8, data memory address width (matches D_addr)
DATA_W, 16, data word width
RD_LAT, 1, memory read latency in cycles from the command edge to valid m_rdata (legal range 1..7)
RR_EN, 1, 1 = round-robin arbitration; 0 = fixed priority with port 0 always winning

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
r0_req  in  1  port 0 access request; held high until r0_gnt is seen
r0_we  in  1  port 0: 1 = write, 0 = read
r0_addr  in  ADDR_W  port 0 address
r0_wdata  in  DATA_W  port 0 write data
r0_gnt  out  1  port 0 grant, one-cycle pulse
r0_rvalid  out  1  port 0 read data valid, one-cycle pulse
r0_rdata  out  DATA_W  port 0 read data
r1_req, r1_we, r1_addr, r1_wdata, r1_gnt, r1_rvalid, r1_rdata  same as port 0, for port 1
m_addr  out  ADDR_W  memory address, registered
m_rd  out  1  memory read strobe, registered
m_wr  out  1  memory write strobe, registered
m_wdata  out  DATA_W  memory write data, registered
m_rdata  in  DATA_W  memory read data
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; last=1, so port 0 wins the first tie.
  - rd_cnt=0.
  - All outputs 0: m_*, gnt, rvalid, rdata, busy.
  - An in-flight read is discarded; no rvalid is issued for it.
- States: IDLE, CMD, RDWAIT.
- IDLE, no req: remain in IDLE; m_rd=m_wr=0.
- IDLE, arbitration when any req is high:
  - One requester: it wins.
  - Both requesters, RR_EN=1: winner = port != last.
  - Both requesters, RR_EN=0: port 0 wins.
  - On the clock edge: m_addr, m_wdata, m_rd=~we and m_wr=we load from the winner; owner<=winner; last<=winner; rN_gnt<=1 for the winner; state goes to CMD.
- CMD (exactly 1 cycle):
  - m_rd/m_wr and the winner's gnt are high in this cycle; the memory samples at the end of it.
  - On exit: m_rd, m_wr and gnt clear to 0.
  - Write: go to IDLE.
  - Read: go to RDWAIT with rd_cnt=RD_LAT-1.
- RDWAIT:
  - If rd_cnt != 0: rd_cnt decrements each cycle.
  - If rd_cnt == 0 (the cycle in which m_rdata is valid): rdata_q<=m_rdata, owner's rvalid<=1, go to IDLE.
- Read-data outputs:
  - r0_rdata and r1_rdata both drive rdata_q.
  - rdata_q holds its value until the next read completes.
  - rvalid is a one-cycle pulse to the owner only.
- Latency:
  - Write: req sampled in IDLE at cycle N -> m_wr and gnt high in N+1 -> arbiter IDLE in N+2.
  - Read: gnt in N+1; rvalid and data in N+2+RD_LAT. For RD_LAT=1, that is N+3.
  - A new request may be accepted in the same IDLE cycle that rvalid is presented.
- Requester rules:
  - Hold req and the command fields stable until gnt.
  - Deassert req, or present a new command, on the edge after the gnt cycle.
  - req is ignored outside IDLE.
  - Maximum throughput: 1 write per 2 cycles; 1 read per 2+RD_LAT cycles.
- Simultaneous events:
  - Both req high in IDLE are resolved by the arbitration rule; the loser keeps req high and is served next.
  - A requester that drops req before gnt loses the request silently; no gnt is issued.
- Fairness: with RR_EN=1 and both ports continuously requesting, grants alternate 0,1,0,1...
- busy is combinational from state.

Test Plan:
- Reset, then r0 write addr=0x12 data=0xBEEF -> m_wr=1, m_addr=0x12, m_wdata=0xBEEF and r0_gnt=1 in the cycle after req; busy low again 2 cycles after req.
- RD_LAT=1: r1 read addr=0x12 with memory returning 0xBEEF -> r1_gnt at N+1, r1_rvalid=1 and r1_rdata=0xBEEF at N+3; r0_rvalid stays 0.
- RR_EN=1: r0 and r1 both request reads continuously -> grant order 0,1,0,1; each rvalid routed to the matching port.
- RR_EN=0: both request continuously -> port 0 granted every time; r1_gnt never asserts.
- RD_LAT=3: r0 read -> rvalid at N+5; a r1 request raised during RDWAIT is granted only after returning to IDLE.
- Assert rst mid-RDWAIT -> all outputs 0 immediately; no rvalid afterwards; first post-reset tie goes to port 0.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Shares a single-port data memory between two requesters. Port 0 is the
//   CPU control unit's D_rd/D_wr path and port 1 is a host/debug loader.
//   Each access follows a req/gnt handshake. Arbitration is round-robin
//   (RR_EN=1) or fixed priority with port 0 always winning (RR_EN=0).
//   The memory command is registered. Read data returns to the owning port
//   with a one-cycle valid strobe, RD_LAT cycles after the command edge.
//
// Ports
//   clk                 system clock, rising edge
//   rst                 asynchronous, active-low reset
//   rN_req/we/addr/wdata  request from port N (N = 0, 1); hold until rN_gnt
//   rN_gnt              one-cycle grant pulse, high during the command cycle
//   rN_rvalid/rdata     read completion strobe; rdata is shared by both ports
//   m_addr/rd/wr/wdata  registered memory command
//   m_rdata             memory read data
//   busy                high whenever the arbiter is not idle
module dmem_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16,
  parameter int RD_LAT = 1,
  parameter int RR_EN  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              r0_req,
  input  logic              r0_we,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic              r0_gnt,
  output logic              r0_rvalid,
  output logic [DATA_W-1:0] r0_rdata,
  input  logic              r1_req,
  input  logic              r1_we,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r1_gnt,
  output logic              r1_rvalid,
  output logic [DATA_W-1:0] r1_rdata,
  output logic [ADDR_W-1:0] m_addr,
  output logic              m_rd,
  output logic              m_wr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, CMD, RDWAIT} state_t;

  // Cycles to wait in RDWAIT before m_rdata is valid.
  localparam logic [2:0] RD_CNT_INIT = 3'(RD_LAT - 1);

  state_t            state, state_d;
  logic              owner;
  logic              last;
  logic              win;
  logic              any_req;
  logic [2:0]        rd_cnt;
  logic [DATA_W-1:0] rdata_q;

  assign any_req = r0_req | r1_req;

  // Winner selection. It is only used in IDLE. On a tie in round-robin mode,
  // the port that did not win last time goes first.
  always_comb begin
    win = 1'b0;
    if (r0_req && r1_req) begin
      if (RR_EN != 0) win = ~last;
    end else if (r1_req) begin
      win = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_d;
  end

  // m_rd is still high in CMD, so it identifies the command type.
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (any_req) state_d = CMD;
      CMD:     state_d = m_rd ? RDWAIT : IDLE;
      RDWAIT:  if (rd_cnt == 3'd0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_addr    <= '0;
      m_wdata   <= '0;
      m_rd      <= 1'b0;
      m_wr      <= 1'b0;
      r0_gnt    <= 1'b0;
      r1_gnt    <= 1'b0;
      r0_rvalid <= 1'b0;
      r1_rvalid <= 1'b0;
      owner     <= 1'b0;
      last      <= 1'b1;
      rd_cnt    <= '0;
      rdata_q   <= '0;
    end else begin
      // Strobes default low, so each one is a single-cycle pulse.
      m_rd      <= 1'b0;
      m_wr      <= 1'b0;
      r0_gnt    <= 1'b0;
      r1_gnt    <= 1'b0;
      r0_rvalid <= 1'b0;
      r1_rvalid <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            m_addr  <= win ? r1_addr  : r0_addr;
            m_wdata <= win ? r1_wdata : r0_wdata;
            m_rd    <= win ? ~r1_we   : ~r0_we;
            m_wr    <= win ? r1_we    : r0_we;
            owner   <= win;
            last    <= win;
            r0_gnt  <= ~win;
            r1_gnt  <= win;
          end
        end
        CMD: begin
          if (m_rd) rd_cnt <= RD_CNT_INIT;
        end
        RDWAIT: begin
          if (rd_cnt != 3'd0) begin
            rd_cnt <= rd_cnt - 3'd1;
          end else begin
            rdata_q   <= m_rdata;
            r0_rvalid <= ~owner;
            r1_rvalid <= owner;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy     = (state != IDLE);
  assign r0_rdata = rdata_q;
  assign r1_rdata = rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter.
//   u_a: RD_LAT=1, RR_EN=1. It is driven from a per-cycle vector table and
//        uses a small RAM model.
//   u_b: RD_LAT=3, RR_EN=0. It is driven by hand-written sequences and uses
//        a memory that returns {8'hA5, addr}.
module tb_dmem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        a_r0_req, a_r0_we, a_r1_req, a_r1_we;
  logic [7:0]  a_r0_addr, a_r1_addr, a_m_addr;
  logic [15:0] a_r0_wdata, a_r1_wdata, a_m_wdata, a_m_rdata;
  logic        a_r0_gnt, a_r1_gnt, a_r0_rvalid, a_r1_rvalid;
  logic [15:0] a_r0_rdata, a_r1_rdata;
  logic        a_m_rd, a_m_wr, a_busy;

  logic        b_r0_req, b_r0_we, b_r1_req, b_r1_we;
  logic [7:0]  b_r0_addr, b_r1_addr, b_m_addr;
  logic [15:0] b_r0_wdata, b_r1_wdata, b_m_wdata, b_m_rdata;
  logic        b_r0_gnt, b_r1_gnt, b_r0_rvalid, b_r1_rvalid;
  logic [15:0] b_r0_rdata, b_r1_rdata;
  logic        b_m_rd, b_m_wr, b_busy;

  dmem_arbiter #(.ADDR_W(8), .DATA_W(16), .RD_LAT(1), .RR_EN(1)) u_a (
    .clk(clk), .rst(rst),
    .r0_req(a_r0_req), .r0_we(a_r0_we), .r0_addr(a_r0_addr), .r0_wdata(a_r0_wdata),
    .r0_gnt(a_r0_gnt), .r0_rvalid(a_r0_rvalid), .r0_rdata(a_r0_rdata),
    .r1_req(a_r1_req), .r1_we(a_r1_we), .r1_addr(a_r1_addr), .r1_wdata(a_r1_wdata),
    .r1_gnt(a_r1_gnt), .r1_rvalid(a_r1_rvalid), .r1_rdata(a_r1_rdata),
    .m_addr(a_m_addr), .m_rd(a_m_rd), .m_wr(a_m_wr), .m_wdata(a_m_wdata),
    .m_rdata(a_m_rdata), .busy(a_busy)
  );

  dmem_arbiter #(.ADDR_W(8), .DATA_W(16), .RD_LAT(3), .RR_EN(0)) u_b (
    .clk(clk), .rst(rst),
    .r0_req(b_r0_req), .r0_we(b_r0_we), .r0_addr(b_r0_addr), .r0_wdata(b_r0_wdata),
    .r0_gnt(b_r0_gnt), .r0_rvalid(b_r0_rvalid), .r0_rdata(b_r0_rdata),
    .r1_req(b_r1_req), .r1_we(b_r1_we), .r1_addr(b_r1_addr), .r1_wdata(b_r1_wdata),
    .r1_gnt(b_r1_gnt), .r1_rvalid(b_r1_rvalid), .r1_rdata(b_r1_rdata),
    .m_addr(b_m_addr), .m_rd(b_m_rd), .m_wr(b_m_wr), .m_wdata(b_m_wdata),
    .m_rdata(b_m_rdata), .busy(b_busy)
  );

  // RAM behind u_a. The address is held through RDWAIT, so a combinational
  // read is valid when the arbiter samples it.
  logic [15:0] mem [256];
  always @(posedge clk) if (a_m_wr) mem[a_m_addr] <= a_m_wdata;
  assign a_m_rdata = mem[a_m_addr];
  assign b_m_rdata = {8'hA5, b_m_addr};

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        r0_req, r0_we;
    logic [7:0]  r0_addr;
    logic [15:0] r0_wdata;
    logic        r1_req, r1_we;
    logic [7:0]  r1_addr;
    logic [15:0] r1_wdata;
    logic [1:0]  gnt;      // {r1, r0}
    logic [1:0]  rvalid;   // {r1, r0}
    logic        m_rd, m_wr;
    logic [7:0]  m_addr;
    logic [15:0] m_wdata;
    logic        busy;
    logic [15:0] rdata;
  } vec_t;

  vec_t tbl[17];

  // Sets the inputs for one cycle and the outputs expected after the next edge.
  function automatic vec_t mk(input logic [25:0] p0, input logic [25:0] p1,
                              input logic [1:0] gnt, input logic [1:0] rv,
                              input logic rd, input logic wr, input logic [7:0] ma,
                              input logic [15:0] mw, input logic bz, input logic [15:0] rdat);
    vec_t v;
    {v.r0_req, v.r0_we, v.r0_addr, v.r0_wdata} = p0;
    {v.r1_req, v.r1_we, v.r1_addr, v.r1_wdata} = p1;
    v.gnt = gnt; v.rvalid = rv; v.m_rd = rd; v.m_wr = wr;
    v.m_addr = ma; v.m_wdata = mw; v.busy = bz; v.rdata = rdat;
    return v;
  endfunction

  localparam logic [25:0] NONE = '0;
  localparam logic [25:0] W0   = {1'b1, 1'b1, 8'h12, 16'hBEEF};
  localparam logic [25:0] W1   = {1'b1, 1'b1, 8'h34, 16'h1234};
  localparam logic [25:0] R12  = {1'b1, 1'b0, 8'h12, 16'h0000};
  localparam logic [25:0] R34  = {1'b1, 1'b0, 8'h34, 16'h0000};

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    {a_r0_req, a_r0_we, a_r0_addr, a_r0_wdata} = NONE;
    {a_r1_req, a_r1_we, a_r1_addr, a_r1_wdata} = NONE;
    {b_r0_req, b_r0_we, b_r0_addr, b_r0_wdata} = NONE;
    {b_r1_req, b_r1_we, b_r1_addr, b_r1_wdata} = NONE;

    //               port0 port1  gnt    rvalid rd    wr    m_addr m_wdata    busy  rdata
    tbl[0]  = mk(W0,   NONE, 2'b01, 2'b00, 1'b0, 1'b1, 8'h12, 16'hBEEF, 1'b1, 16'h0000);
    tbl[1]  = mk(W0,   NONE, 2'b00, 2'b00, 1'b0, 1'b0, 8'h12, 16'hBEEF, 1'b0, 16'h0000);
    tbl[2]  = mk(NONE, R12,  2'b10, 2'b00, 1'b1, 1'b0, 8'h12, 16'h0000, 1'b1, 16'h0000);
    tbl[3]  = mk(NONE, R12,  2'b00, 2'b00, 1'b0, 1'b0, 8'h12, 16'h0000, 1'b1, 16'h0000);
    tbl[4]  = mk(NONE, NONE, 2'b00, 2'b10, 1'b0, 1'b0, 8'h12, 16'h0000, 1'b0, 16'hBEEF);
    tbl[5]  = mk(NONE, W1,   2'b10, 2'b00, 1'b0, 1'b1, 8'h34, 16'h1234, 1'b1, 16'hBEEF);
    tbl[6]  = mk(NONE, W1,   2'b00, 2'b00, 1'b0, 1'b0, 8'h34, 16'h1234, 1'b0, 16'hBEEF);
    tbl[7]  = mk(R12,  R34,  2'b01, 2'b00, 1'b1, 1'b0, 8'h12, 16'h0000, 1'b1, 16'hBEEF);
    tbl[8]  = mk(R12,  R34,  2'b00, 2'b00, 1'b0, 1'b0, 8'h12, 16'h0000, 1'b1, 16'hBEEF);
    tbl[9]  = mk(R12,  R34,  2'b00, 2'b01, 1'b0, 1'b0, 8'h12, 16'h0000, 1'b0, 16'hBEEF);
    tbl[10] = mk(R12,  R34,  2'b10, 2'b00, 1'b1, 1'b0, 8'h34, 16'h0000, 1'b1, 16'hBEEF);
    tbl[11] = mk(R12,  R34,  2'b00, 2'b00, 1'b0, 1'b0, 8'h34, 16'h0000, 1'b1, 16'hBEEF);
    tbl[12] = mk(R12,  R34,  2'b00, 2'b10, 1'b0, 1'b0, 8'h34, 16'h0000, 1'b0, 16'h1234);
    tbl[13] = mk(R12,  R34,  2'b01, 2'b00, 1'b1, 1'b0, 8'h12, 16'h0000, 1'b1, 16'h1234);
    tbl[14] = mk(R12,  R34,  2'b00, 2'b00, 1'b0, 1'b0, 8'h12, 16'h0000, 1'b1, 16'h1234);
    tbl[15] = mk(NONE, R34,  2'b00, 2'b01, 1'b0, 1'b0, 8'h12, 16'h0000, 1'b0, 16'hBEEF);
    tbl[16] = mk(NONE, NONE, 2'b00, 2'b00, 1'b0, 1'b0, 8'h12, 16'h0000, 1'b0, 16'hBEEF);

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_a_ctrl", 32'({a_r0_gnt, a_r1_gnt, a_r0_rvalid, a_r1_rvalid, a_m_rd, a_m_wr, a_busy}), 32'h0);
    chk("rst_a_maddr", 32'(a_m_addr), 32'h0);
    chk("rst_a_rdata", 32'({a_r0_rdata, a_r1_rdata}), 32'h0);
    chk("rst_b_ctrl", 32'({b_r0_gnt, b_r1_gnt, b_r0_rvalid, b_r1_rvalid, b_m_rd, b_m_wr, b_busy}), 32'h0);
    @(negedge clk);
    rst = 1'b1;

    // Table-driven run on u_a.
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      {a_r0_req, a_r0_we, a_r0_addr, a_r0_wdata} = {tbl[i].r0_req, tbl[i].r0_we, tbl[i].r0_addr, tbl[i].r0_wdata};
      {a_r1_req, a_r1_we, a_r1_addr, a_r1_wdata} = {tbl[i].r1_req, tbl[i].r1_we, tbl[i].r1_addr, tbl[i].r1_wdata};
      @(posedge clk);
      #1;
      chk($sformatf("v%0d.gnt", i),     32'({a_r1_gnt, a_r0_gnt}), 32'(tbl[i].gnt));
      chk($sformatf("v%0d.rvalid", i),  32'({a_r1_rvalid, a_r0_rvalid}), 32'(tbl[i].rvalid));
      chk($sformatf("v%0d.m_rdwr", i),  32'({a_m_rd, a_m_wr}), 32'({tbl[i].m_rd, tbl[i].m_wr}));
      chk($sformatf("v%0d.m_addr", i),  32'(a_m_addr), 32'(tbl[i].m_addr));
      chk($sformatf("v%0d.m_wdata", i), 32'(a_m_wdata), 32'(tbl[i].m_wdata));
      chk($sformatf("v%0d.busy", i),    32'(a_busy), 32'(tbl[i].busy));
      chk($sformatf("v%0d.r0_rdata", i), 32'(a_r0_rdata), 32'(tbl[i].rdata));
      chk($sformatf("v%0d.r1_rdata", i), 32'(a_r1_rdata), 32'(tbl[i].rdata));
    end

    // u_b, RD_LAT=3: r0 reads 0x40 and r1 requests during RDWAIT.
    @(negedge clk);
    {b_r0_req, b_r0_we, b_r0_addr} = {1'b1, 1'b0, 8'h40};
    @(posedge clk); #1;
    chk("lat3_r0_gnt", 32'({b_r1_gnt, b_r0_gnt, b_m_rd}), 32'b011);
    @(negedge clk);
    b_r0_req = 1'b0;
    @(posedge clk); #1;
    chk("lat3_rdwait_busy", 32'(b_busy), 32'h1);
    @(negedge clk);
    {b_r1_req, b_r1_we, b_r1_addr} = {1'b1, 1'b0, 8'h41};
    for (int k = 3; k <= 5; k++) begin
      @(posedge clk); #1;
      chk($sformatf("lat3_e%0d_r1_gnt", k), 32'(b_r1_gnt), 32'h0);
      chk($sformatf("lat3_e%0d_r0_rvalid", k), 32'({b_r1_rvalid, b_r0_rvalid}), (k == 5) ? 32'h1 : 32'h0);
    end
    chk("lat3_r0_rdata", 32'(b_r0_rdata), 32'h0000A540);
    @(posedge clk); #1;
    chk("lat3_r1_gnt_after_idle", 32'({b_r1_gnt, b_r0_gnt}), 32'b10);
    @(negedge clk);
    b_r1_req = 1'b0;
    for (int k = 7; k <= 10; k++) begin
      @(posedge clk); #1;
      chk($sformatf("lat3_e%0d_r1_rvalid", k), 32'({b_r1_rvalid, b_r0_rvalid}), (k == 10) ? 32'b10 : 32'b00);
    end
    chk("lat3_r1_rdata", 32'(b_r1_rdata), 32'h0000A541);

    // u_b, fixed priority: both ports request continuously.
    begin
      int g0, g1, v0, v1;
      g0 = 0; g1 = 0; v0 = 0; v1 = 0;
      @(negedge clk);
      {b_r0_req, b_r0_we, b_r0_addr} = {1'b1, 1'b0, 8'h50};
      {b_r1_req, b_r1_we, b_r1_addr} = {1'b1, 1'b0, 8'h51};
      for (int k = 1; k <= 20; k++) begin
        @(posedge clk); #1;
        g0 += int'(b_r0_gnt); g1 += int'(b_r1_gnt);
        v0 += int'(b_r0_rvalid); v1 += int'(b_r1_rvalid);
      end
      @(negedge clk);
      b_r0_req = 1'b0; b_r1_req = 1'b0;
      chk("fixed_r0_gnts", 32'(g0), 32'd4);
      chk("fixed_r1_gnts", 32'(g1), 32'd0);
      chk("fixed_r0_rvalids", 32'(v0), 32'd4);
      chk("fixed_r1_rvalids", 32'(v1), 32'd0);
    end
    repeat (3) @(posedge clk);

    // Reset asserted mid-RDWAIT on both instances.
    @(negedge clk);
    {a_r0_req, a_r0_we, a_r0_addr} = {1'b1, 1'b0, 8'h12};
    {b_r0_req, b_r0_we, b_r0_addr} = {1'b1, 1'b0, 8'h60};
    @(posedge clk);
    @(negedge clk);
    a_r0_req = 1'b0; b_r0_req = 1'b0;
    @(posedge clk); #2;
    chk("pre_rst_a_busy", 32'({a_busy, b_busy}), 32'b11);
    rst = 1'b0;
    #1;
    chk("mid_rst_a_ctrl", 32'({a_r0_gnt, a_r1_gnt, a_r0_rvalid, a_r1_rvalid, a_m_rd, a_m_wr, a_busy}), 32'h0);
    chk("mid_rst_a_maddr", 32'({a_m_addr, a_m_wdata}), 32'h0);
    chk("mid_rst_a_rdata", 32'({a_r0_rdata, a_r1_rdata}), 32'h0);
    chk("mid_rst_b_ctrl", 32'({b_r0_gnt, b_r1_gnt, b_r0_rvalid, b_r1_rvalid, b_m_rd, b_m_wr, b_busy}), 32'h0);
    chk("mid_rst_b_maddr", 32'({b_m_addr, b_m_wdata}), 32'h0);
    chk("mid_rst_b_rdata", 32'({b_r0_rdata, b_r1_rdata}), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    begin
      int nv;
      nv = 0;
      for (int k = 0; k < 5; k++) begin
        @(posedge clk); #1;
        nv += int'(a_r0_rvalid) + int'(a_r1_rvalid) + int'(b_r0_rvalid) + int'(b_r1_rvalid);
      end
      chk("post_rst_no_rvalid", 32'(nv), 32'd0);
    end

    // First tie after reset goes to port 0.
    @(negedge clk);
    {a_r0_req, a_r0_we, a_r0_addr} = {1'b1, 1'b0, 8'h12};
    {a_r1_req, a_r1_we, a_r1_addr} = {1'b1, 1'b0, 8'h34};
    {b_r0_req, b_r0_we, b_r0_addr} = {1'b1, 1'b0, 8'h70};
    {b_r1_req, b_r1_we, b_r1_addr} = {1'b1, 1'b0, 8'h71};
    @(posedge clk); #1;
    chk("post_rst_tie_a", 32'({a_r1_gnt, a_r0_gnt}), 32'b01);
    chk("post_rst_tie_b", 32'({b_r1_gnt, b_r0_gnt}), 32'b01);
    @(negedge clk);
    a_r0_req = 1'b0; a_r1_req = 1'b0; b_r0_req = 1'b0; b_r1_req = 1'b0;
    repeat (8) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
